led_seq_ctrl: RTL and testbench

LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

---
 rtl/led_seq_ctrl_if.sv | 23 ++
 rtl/led_seq_ctrl.sv | 175 +++++++++++++++++
 tb/tb_led_seq_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/led_seq_ctrl_if.sv
// Strobe/button inputs and LED bank outputs of the LED sequencer, bundled as
// one port. The slave side is the sequencer; the master side drives it.
interface led_seq_ctrl_if #(
    parameter int NB_LEDS = 4
);
    logic               i_tick;
    logic [3:0]         i_btn;
    logic [NB_LEDS-1:0] o_led_r;
    logic [NB_LEDS-1:0] o_led_g;
    logic [NB_LEDS-1:0] o_led_b;
    logic [1:0]         o_speed_sel;
    logic               o_run;

    modport master (
        output i_tick, i_btn,
        input  o_led_r, o_led_g, o_led_b, o_speed_sel, o_run
    );

    modport slave (
        input  i_tick, i_btn,
        output o_led_r, o_led_g, o_led_b, o_speed_sel, o_run
    );
endinterface

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: four synchronised buttons select run/pause, pattern
// mode, colour bank and rate code; the pattern steps on each rate tick.

// One button lane: NB_SYNC-flop synchroniser followed by a rising-edge
// detector, giving a single-cycle press pulse per 0->1 transition.
module led_seq_btn_edge #(
    parameter int NB_SYNC = 2
) (
    input  logic clock,
    input  logic i_reset,
    input  logic btn_i,
    output logic press_o
);
    logic [NB_SYNC-1:0] sync_q;
    logic               prev_q;

    // Shift the raw button in at bit 0; the top bit is the synchronised level.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= NB_SYNC'({sync_q, btn_i});
            prev_q <= sync_q[NB_SYNC-1];
        end
    end

    assign press_o = sync_q[NB_SYNC-1] & ~prev_q;
endmodule

module led_seq_ctrl #(
    parameter int NB_LEDS = 4,
    parameter int NB_SYNC = 2
) (
    input  logic           clock,
    input  logic           i_reset,
    led_seq_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        MODE_LEFT     = 2'd0,
        MODE_RIGHT    = 2'd1,
        MODE_PINGPONG = 2'd2,
        MODE_FLASH    = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        COL_RED   = 3'b001,
        COL_GREEN = 3'b010,
        COL_BLUE  = 3'b100
    } colour_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Reload patterns: single lit LSB, and alternating ...0101 for FLASH.
    localparam logic [NB_LEDS-1:0] PAT_ONE = NB_LEDS'(1);
    localparam logic [NB_LEDS-1:0] PAT_ALT = NB_LEDS'({NB_LEDS{2'b01}});

    // Button order: [0] run/pause, [1] mode, [2] colour, [3] speed.
    logic [3:0] press;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_btn
            led_seq_btn_edge #(.NB_SYNC(NB_SYNC)) u_btn (
                .clock   (clock),
                .i_reset (i_reset),
                .btn_i   (bus.i_btn[g]),
                .press_o (press[g])
            );
        end
    endgenerate

    mode_e              mode_q, mode_d;
    logic [NB_LEDS-1:0] pat_q, pat_d;
    logic               dir_q, dir_d;
    logic               run_q, run_d;
    logic [1:0]         spd_q, spd_d;
    colour_e            colour_q, colour_d;
    logic [NB_LEDS-1:0] led_r_q, led_g_q, led_b_q;

    // Next-state for pattern, mode, direction, run and speed. A mode press
    // reloads and swallows a coincident tick; the tick is gated by the
    // run flag as it was before any same-cycle run/pause toggle.
    always_comb begin
        mode_d = mode_q;
        pat_d  = pat_q;
        dir_d  = dir_q;
        run_d  = run_q;
        spd_d  = spd_q;
        if (press[1]) begin
            mode_d = mode_e'(mode_q + 2'd1);
            pat_d  = (mode_d == MODE_FLASH) ? PAT_ALT : PAT_ONE;
            dir_d  = DIR_LEFT;
        end else if (bus.i_tick && run_q) begin
            case (mode_q)
                MODE_LEFT:  pat_d = {pat_q[NB_LEDS-2:0], pat_q[NB_LEDS-1]};
                MODE_RIGHT: pat_d = {pat_q[0], pat_q[NB_LEDS-1:1]};
                MODE_PINGPONG: begin
                    // Turn around on the same tick that reaches an end.
                    if (dir_q == DIR_LEFT) begin
                        if (pat_q[NB_LEDS-1]) begin
                            dir_d = DIR_RIGHT;
                            pat_d = pat_q >> 1;
                        end else begin
                            pat_d = pat_q << 1;
                        end
                    end else begin
                        if (pat_q[0]) begin
                            dir_d = DIR_LEFT;
                            pat_d = pat_q << 1;
                        end else begin
                            pat_d = pat_q >> 1;
                        end
                    end
                end
                MODE_FLASH: pat_d = ~pat_q;
            endcase
        end
        if (press[0]) run_d = ~run_q;
        if (press[3]) spd_d = spd_q + 2'd1;
    end

    // Colour next-state: RED -> GREEN -> BLUE -> RED on each colour press.
    always_comb begin
        colour_d = colour_q;
        if (press[2]) begin
            case (colour_q)
                COL_RED:   colour_d = COL_GREEN;
                COL_GREEN: colour_d = COL_BLUE;
                COL_BLUE:  colour_d = COL_RED;
                default:   colour_d = COL_RED;
            endcase
        end
    end

    // Pattern/mode/run/speed state registers.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            mode_q <= MODE_LEFT;
            pat_q  <= PAT_ONE;
            dir_q  <= DIR_LEFT;
            run_q  <= 1'b1;
            spd_q  <= 2'd0;
        end else begin
            mode_q <= mode_d;
            pat_q  <= pat_d;
            dir_q  <= dir_d;
            run_q  <= run_d;
            spd_q  <= spd_d;
        end
    end

    // Colour FSM with registered bank outputs built from next-state, so a
    // tick or press shows on the banks at the same edge it is taken.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            colour_q <= COL_RED;
            led_r_q  <= PAT_ONE;
            led_g_q  <= '0;
            led_b_q  <= '0;
        end else begin
            colour_q <= colour_d;
            led_r_q  <= (colour_d == COL_RED)   ? pat_d : '0;
            led_g_q  <= (colour_d == COL_GREEN) ? pat_d : '0;
            led_b_q  <= (colour_d == COL_BLUE)  ? pat_d : '0;
        end
    end

    assign bus.o_led_r     = led_r_q;
    assign bus.o_led_g     = led_g_q;
    assign bus.o_led_b     = led_b_q;
    assign bus.o_speed_sel = spd_q;
    assign bus.o_run       = run_q;
endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl: a table of tick/press actions with
// hand-computed bank/speed/run results, then hand-written corner sequences.
module tb_led_seq_ctrl;
    localparam int N = 4;

    localparam logic [1:0] A_TICK  = 2'd0;
    localparam logic [1:0] A_PRESS = 2'd1;

    typedef struct {
        logic [1:0] act;
        logic [3:0] btn;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic [1:0] spd;
        logic       run;
    } vec_t;

    logic clock = 1'b0;
    logic i_reset;
    int   tests = 0;
    int   fails = 0;
    vec_t vq[$];

    led_seq_ctrl_if #(.NB_LEDS(N)) bus();

    led_seq_ctrl #(.NB_LEDS(N), .NB_SYNC(2)) dut (
        .clock   (clock),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(input logic [1:0] a, input logic [3:0] btn,
                                input logic [3:0] r, input logic [3:0] g,
                                input logic [3:0] b, input logic [1:0] s,
                                input logic run);
        vec_t v;
        v.act = a; v.btn = btn; v.r = r; v.g = g; v.b = b; v.spd = s; v.run = run;
        return v;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] r, input logic [3:0] g,
                         input logic [3:0] b, input logic [1:0] s, input logic run);
        tests++;
        if ({bus.o_led_r, bus.o_led_g, bus.o_led_b, bus.o_speed_sel, bus.o_run} !==
            {r, g, b, s, run}) begin
            fails++;
            $display("FAIL %s: got r=%b g=%b b=%b spd=%0d run=%b, want r=%b g=%b b=%b spd=%0d run=%b",
                     name, bus.o_led_r, bus.o_led_g, bus.o_led_b, bus.o_speed_sel, bus.o_run,
                     r, g, b, s, run);
        end
    endtask

    task automatic do_tick();
        bus.i_tick = 1'b1;
        step();
        bus.i_tick = 1'b0;
    endtask

    // One-cycle button pulse; the press lands on the third edge, optionally
    // together with a tick on that same edge.
    task automatic do_press(input logic [3:0] m, input logic tick_at_effect);
        bus.i_btn = m;
        step();
        bus.i_btn = 4'b0000;
        step();
        bus.i_tick = tick_at_effect;
        step();
        bus.i_tick = 1'b0;
    endtask

    initial begin
        // Action table, starting from reset (LEFT, 0001, RED, speed 0, running).
        vq.push_back(mk(A_TICK,  4'b0000, 4'b0010, 4'b0000, 4'b0000, 2'd0, 1'b1));
        vq.push_back(mk(A_TICK,  4'b0000, 4'b0100, 4'b0000, 4'b0000, 2'd0, 1'b1));
        vq.push_back(mk(A_TICK,  4'b0000, 4'b1000, 4'b0000, 4'b0000, 2'd0, 1'b1));
        vq.push_back(mk(A_TICK,  4'b0000, 4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b1));
        vq.push_back(mk(A_TICK,  4'b0000, 4'b0010, 4'b0000, 4'b0000, 2'd0, 1'b1));
        // Speed presses 1,2,3,0.
        vq.push_back(mk(A_PRESS, 4'b1000, 4'b0010, 4'b0000, 4'b0000, 2'd1, 1'b1));
        vq.push_back(mk(A_PRESS, 4'b1000, 4'b0010, 4'b0000, 4'b0000, 2'd2, 1'b1));
        vq.push_back(mk(A_PRESS, 4'b1000, 4'b0010, 4'b0000, 4'b0000, 2'd3, 1'b1));
        vq.push_back(mk(A_PRESS, 4'b1000, 4'b0010, 4'b0000, 4'b0000, 2'd0, 1'b1));
        // RIGHT: reload then rotate right with wrap.
        vq.push_back(mk(A_PRESS, 4'b0010, 4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b1));
        vq.push_back(mk(A_TICK,  4'b0000, 4'b1000, 4'b0000, 4'b0000, 2'd0, 1'b1));
        vq.push_back(mk(A_TICK,  4'b0000, 4'b0100, 4'b0000, 4'b0000, 2'd0, 1'b1));
        // PINGPONG: reload then 8 ticks.
        vq.push_back(mk(A_PRESS, 4'b0010, 4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b1));
        vq.push_back(mk(A_TICK,  4'b0000, 4'b0010, 4'b0000, 4'b0000, 2'd0, 1'b1));
        vq.push_back(mk(A_TICK,  4'b0000, 4'b0100, 4'b0000, 4'b0000, 2'd0, 1'b1));
        vq.push_back(mk(A_TICK,  4'b0000, 4'b1000, 4'b0000, 4'b0000, 2'd0, 1'b1));
        vq.push_back(mk(A_TICK,  4'b0000, 4'b0100, 4'b0000, 4'b0000, 2'd0, 1'b1));
        vq.push_back(mk(A_TICK,  4'b0000, 4'b0010, 4'b0000, 4'b0000, 2'd0, 1'b1));
        vq.push_back(mk(A_TICK,  4'b0000, 4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b1));
        vq.push_back(mk(A_TICK,  4'b0000, 4'b0010, 4'b0000, 4'b0000, 2'd0, 1'b1));
        vq.push_back(mk(A_TICK,  4'b0000, 4'b0100, 4'b0000, 4'b0000, 2'd0, 1'b1));
        // Colour walk: GREEN, tick, BLUE, RED.
        vq.push_back(mk(A_PRESS, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 2'd0, 1'b1));
        vq.push_back(mk(A_TICK,  4'b0000, 4'b0000, 4'b1000, 4'b0000, 2'd0, 1'b1));
        vq.push_back(mk(A_PRESS, 4'b0100, 4'b0000, 4'b0000, 4'b1000, 2'd0, 1'b1));
        vq.push_back(mk(A_PRESS, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 2'd0, 1'b1));
        // Pause, ticks ignored, resume, tick turns pingpong around.
        vq.push_back(mk(A_PRESS, 4'b0001, 4'b1000, 4'b0000, 4'b0000, 2'd0, 1'b0));
        vq.push_back(mk(A_TICK,  4'b0000, 4'b1000, 4'b0000, 4'b0000, 2'd0, 1'b0));
        vq.push_back(mk(A_TICK,  4'b0000, 4'b1000, 4'b0000, 4'b0000, 2'd0, 1'b0));
        vq.push_back(mk(A_TICK,  4'b0000, 4'b1000, 4'b0000, 4'b0000, 2'd0, 1'b0));
        vq.push_back(mk(A_PRESS, 4'b0001, 4'b1000, 4'b0000, 4'b0000, 2'd0, 1'b1));
        vq.push_back(mk(A_TICK,  4'b0000, 4'b0100, 4'b0000, 4'b0000, 2'd0, 1'b1));
        // FLASH then back to LEFT.
        vq.push_back(mk(A_PRESS, 4'b0010, 4'b0101, 4'b0000, 4'b0000, 2'd0, 1'b1));
        vq.push_back(mk(A_TICK,  4'b0000, 4'b1010, 4'b0000, 4'b0000, 2'd0, 1'b1));
        vq.push_back(mk(A_TICK,  4'b0000, 4'b0101, 4'b0000, 4'b0000, 2'd0, 1'b1));
        vq.push_back(mk(A_PRESS, 4'b0010, 4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b1));

        bus.i_tick = 1'b0;
        bus.i_btn  = 4'b0000;
        i_reset    = 1'b0;
        #12;
        i_reset = 1'b1;
        #1;
        check("reset", 4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b1);

        foreach (vq[i]) begin
            if (vq[i].act == A_TICK) do_tick();
            else                     do_press(vq[i].btn, 1'b0);
            check($sformatf("vec%0d", i), vq[i].r, vq[i].g, vq[i].b, vq[i].spd, vq[i].run);
        end

        // Held colour button: one advance, visible on the third edge only.
        bus.i_btn = 4'b0100;
        step();
        step();
        check("hold_edge2", 4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b1);
        step();
        check("hold_edge3", 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b1);
        repeat (17) step();
        check("hold_end", 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b1);
        bus.i_btn = 4'b0000;
        repeat (4) step();
        check("hold_release", 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b1);

        // Mode press coinciding with a tick: reload wins.
        do_press(4'b0010, 1'b0);
        do_press(4'b0010, 1'b0);
        do_press(4'b0010, 1'b1);
        check("flash_entry_tick", 4'b0000, 4'b0101, 4'b0000, 2'd0, 1'b1);
        do_tick();
        check("flash_next", 4'b0000, 4'b1010, 4'b0000, 2'd0, 1'b1);

        // Run press coinciding with a tick: tick sees the pre-toggle run flag.
        do_press(4'b0001, 1'b1);
        check("pause_with_tick", 4'b0000, 4'b0101, 4'b0000, 2'd0, 1'b0);
        do_tick();
        check("paused_tick", 4'b0000, 4'b0101, 4'b0000, 2'd0, 1'b0);
        do_press(4'b0001, 1'b1);
        check("resume_with_tick", 4'b0000, 4'b0101, 4'b0000, 2'd0, 1'b1);
        do_tick();
        check("resumed_tick", 4'b0000, 4'b1010, 4'b0000, 2'd0, 1'b1);

        // Mode, colour and speed pressed together.
        do_press(4'b1110, 1'b0);
        check("multi_press", 4'b0000, 4'b0000, 4'b0001, 2'd1, 1'b1);

        // Asynchronous reset between edges mid-PINGPONG.
        do_press(4'b0010, 1'b0);
        do_press(4'b0010, 1'b0);
        do_tick();
        do_tick();
        check("pp_before_reset", 4'b0000, 4'b0000, 4'b0100, 2'd1, 1'b1);
        #2;
        i_reset = 1'b0;
        #1;
        check("async_reset", 4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b1);
        step();
        check("reset_held", 4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b1);
        i_reset = 1'b1;

        // A mode press in flight when reset hits must be dropped.
        bus.i_btn = 4'b0010;
        step();
        bus.i_btn = 4'b0000;
        #2;
        i_reset = 1'b0;
        #1;
        i_reset = 1'b1;
        repeat (3) step();
        check("press_abandoned", 4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b1);
        do_tick();
        check("first_tick_after_reset", 4'b0010, 4'b0000, 4'b0000, 2'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
